// File: rtl/tdm_demux.sv
// tdm_demux -- serial TDM receiver. Locks onto frame boundaries from a
// 1-bit stream with frame sync and distributes each time slot into its own
// parallel channel register.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bit_en     serial bit strobe; din/fsync are sampled only when it is 1
//   din        serial data bit, MSB of each slot first
//   fsync      frame sync; 1 marks the current bit as channel 0 MSB
//   ch_data    channel registers, channel k at [k*CH_W +: CH_W]
//   ch_valid   one-cycle pulse for the channel whose register just updated
//   frame_done one-cycle pulse together with ch_valid[NUM_CH-1]
//   locked     1 while the receiver is in RECV (this is the FSM state view)
//   sync_err   one-cycle pulse on a missing or misplaced frame sync
//
// Interface protocol: there is no backpressure. A bit is transferred on every
// rising edge where bit_en=1. Every output pulse is registered and appears in
// the cycle right after the bit_en cycle that caused it, and lasts one cycle.
// ch_data only changes in a cycle where the matching ch_valid bit is 1.
module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_en,
  input  logic                     din,
  input  logic                     fsync,
  output logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int BW = $clog2(CH_W);
  localparam int CW = $clog2(NUM_CH);
  localparam int SW = CH_W - 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CH_W - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]            ch_cnt_q, ch_cnt_d;
  // Only CH_W-1 bits are stored: the LSB arrives on din and completes the slot.
  logic [SW-1:0]            shift_q, shift_d;
  logic [NUM_CH*CH_W-1:0]   ch_data_d;
  logic [NUM_CH-1:0]        ch_valid_d;
  logic                     frame_done_d;
  logic                     sync_err_d;
  logic [CH_W-1:0]          shifted;
  logic                     at_start;

  assign locked = (state_q == RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      ch_cnt_q   <= '0;
      shift_q    <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      shift_q    <= shift_d;
      ch_data    <= ch_data_d;
      ch_valid   <= ch_valid_d;
      frame_done <= frame_done_d;
      sync_err   <= sync_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    shift_d      = shift_q;
    ch_data_d    = ch_data;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    shifted      = {shift_q, din};
    at_start     = (bit_cnt_q == '0) && (ch_cnt_q == '0);

    if (bit_en) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            shift_d    = '0;
            shift_d[0] = din;
            bit_cnt_d  = BW'(1);
            ch_cnt_d   = '0;
            state_d    = RECV;
          end
        end
        RECV: begin
          if (fsync && !at_start) begin
            // Misplaced sync: drop the partial slot and restart the frame on this bit.
            sync_err_d = 1'b1;
            shift_d    = '0;
            shift_d[0] = din;
            bit_cnt_d  = BW'(1);
            ch_cnt_d   = '0;
          end else if (!fsync && at_start) begin
            // Missing sync: this bit is not trusted, go back to hunting.
            sync_err_d = 1'b1;
            shift_d    = '0;
            bit_cnt_d  = '0;
            ch_cnt_d   = '0;
            state_d    = HUNT;
          end else if (bit_cnt_q == BIT_LAST) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_cnt_q == CW'(k)) begin
                ch_data_d[k*CH_W +: CH_W] = shifted;
                ch_valid_d[k]             = 1'b1;
              end
            end
            frame_done_d = (ch_cnt_q == CH_LAST);
            shift_d      = '0;
            bit_cnt_d    = '0;
            ch_cnt_d     = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CW'(1);
          end else begin
            shift_d   = shifted[SW-1:0];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux -- randomized and directed stimulus for tdm_demux with a
// frame-position reference model and an expected-event scoreboard.
module tb_tdm_demux;

  localparam int NUM_CH     = 4;
  localparam int CH_W       = 8;
  localparam int DW         = NUM_CH * CH_W;
  localparam int FRAME_BITS = NUM_CH * CH_W;
  localparam int EW         = 2 + NUM_CH + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_en = 1'b0;
  logic din = 1'b0;
  logic fsync = 1'b0;
  logic [DW-1:0]     ch_data;
  logic [NUM_CH-1:0] ch_valid;
  logic              frame_done;
  logic              locked;
  logic              sync_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  tdm_demux #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .din(din), .fsync(fsync),
    .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done),
    .locked(locked), .sync_err(sync_err)
  );

  // ---------------- scoreboard state ----------------
  // Event word: {sync_err, frame_done, ch_valid, ch_data}
  logic [EW-1:0] exp_q[$];
  int            exp_t_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_fd  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: position p inside the frame, slot = p / CH_W.
  bit            m_locked = 1'b0;
  int            m_p = 0;
  int            m_acc = 0;
  logic [DW-1:0] m_data = '0;

  task automatic push_exp(input logic [EW-1:0] e);
    exp_q.push_back(e);
    exp_t_q.push_back(cyc);
  endtask

  task automatic model_bit(input logic d, input logic f);
    int slot;
    logic [NUM_CH-1:0] vbits;
    if (!m_locked) begin
      if (f) begin
        m_locked = 1'b1;
        m_acc    = int'(d);
        m_p      = 1;
      end
    end else if (f && m_p != 0) begin
      push_exp({1'b1, 1'b0, {NUM_CH{1'b0}}, m_data});
      m_acc = int'(d);
      m_p   = 1;
    end else if (!f && m_p == 0) begin
      push_exp({1'b1, 1'b0, {NUM_CH{1'b0}}, m_data});
      m_locked = 1'b0;
      m_p      = 0;
    end else begin
      m_acc = (m_p % CH_W == 0) ? int'(d) : m_acc * 2 + int'(d);
      if (m_p % CH_W == CH_W - 1) begin
        slot = m_p / CH_W;
        m_data[slot*CH_W +: CH_W] = m_acc[CH_W-1:0];
        vbits = '0;
        vbits[slot] = 1'b1;
        push_exp({1'b0, (slot == NUM_CH - 1), vbits, m_data});
      end
      m_p = (m_p + 1) % FRAME_BITS;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bit_en = 1'b0;
      din    = 1'($urandom_range(0, 1));
      fsync  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_bit(input logic d, input logic f, input int gap);
    @(posedge clk); #1;
    check("locked", 64'(locked), 64'(m_locked));
    bit_en = 1'b1;
    din    = d;
    fsync  = f;
    model_bit(d, f);
    if (gap > 0) idle(gap);
  endtask

  task automatic send_slot(input logic [CH_W-1:0] v, input logic f, input int gap);
    for (int i = CH_W - 1; i >= 0; i--) send_bit(v[i], f && (i == CH_W - 1), gap);
  endtask

  task automatic send_frame(input logic [DW-1:0] fr, input int gap);
    for (int k = 0; k < NUM_CH; k++) send_slot(fr[k*CH_W +: CH_W], (k == 0), gap);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ch_data"},    64'(ch_data),    64'(0));
    check({tag, "_ch_valid"},   64'(ch_valid),   64'(0));
    check({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    check({tag, "_sync_err"},   64'(sync_err),   64'(0));
    check({tag, "_locked"},     64'(locked),     64'(0));
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst_n  = 1'b0;
    bit_en = 1'b0;
    #1;
    check_quiet("async_reset");
    m_locked = 1'b0;
    m_p      = 0;
    m_data   = '0;
    exp_q.delete();
    exp_t_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [DW-1:0]     mon_data = '0;
  logic [EW-1:0]     mon_e;
  int                mon_t;
  logic [NUM_CH+1:0] pulses;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_data = '0;
    end else begin
      pulses = {sync_err, frame_done, ch_valid};
      if (pulses != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'(pulses), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = exp_t_q.pop_front();
          check("event", 64'({pulses, ch_data}), 64'(mon_e));
          check("latency", 64'(cyc), 64'(mon_t + 1));
          mon_data = mon_e[DW-1:0];
          if (frame_done) n_fd++;
        end
      end else begin
        check("hold", 64'(ch_data), 64'(mon_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  int fd_before;
  logic f_r;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;

    // Hunting: no sync, no error
    for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);

    // Single frame, continuous strobe
    send_frame(32'h01FF3CA5, 0);
    idle(3);
    check("frame1_data", 64'(ch_data), 64'h01FF3CA5);

    // Async reset in the middle of a slot
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    async_reset();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
    idle(2);

    // Gapped strobe
    send_frame(32'h01FF3CA5, 2);
    idle(3);
    check("gapped_data", 64'(ch_data), 64'h01FF3CA5);

    // Back-to-back frames
    fd_before = n_fd;
    send_frame(32'h44332211, 0);
    send_frame(32'h88776655, 0);
    idle(3);
    check("b2b_data", 64'(ch_data), 64'h88776655);
    check("b2b_frame_done", 64'(n_fd - fd_before), 64'(2));

    // Missing sync on second frame, then relock
    send_frame(32'h44332211, 0);
    send_slot(8'h55, 1'b0, 0);
    idle(3);
    check("missing_sync_locked", 64'(locked), 64'(0));
    check("missing_sync_data", 64'(ch_data), 64'h44332211);
    send_frame(32'h88776655, 0);
    idle(3);
    check("relock_data", 64'(ch_data), 64'h88776655);

    // Early sync at bit 3 of channel 2
    send_slot(8'h11, 1'b1, 0);
    send_slot(8'h22, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_frame(32'hDDCCBBAA, 0);
    idle(3);
    check("early_sync_data", 64'(ch_data), 64'hDDCCBBAA);

    // Randomized stream with occasional framing faults
    for (int i = 0; i < 600; i++) begin
      if (m_locked && m_p == 0) f_r = ($urandom_range(0, 15) != 0);
      else if (m_locked)        f_r = ($urandom_range(0, 59) == 0);
      else                      f_r = ($urandom_range(0, 3) == 0);
      send_bit(1'($urandom_range(0, 1)), f_r,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
    idle(4);
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-end counterpart of the team's 2:1 select mux, scaled to time-division multiplexing.
- Takes a 1-bit serial TDM stream with frame sync, locks onto frame boundaries, and distributes each time slot into its own parallel channel register.
- Sits at the receive end of the serial link and feeds per-channel consumers.

Parameters:
- NUM_CH, 4, number of time slots (channels) per frame; must be >= 2.
- CH_W, 8, bits per channel slot; must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bit_en  input  1  serial bit strobe; din and fsync are sampled only when bit_en=1.
- din  input  1  serial data bit, MSB of each slot first.
- fsync  input  1  frame sync; 1 marks the current bit as channel 0 MSB.
- ch_data  output  NUM_CH*CH_W  channel registers; channel k occupies bits [k*CH_W +: CH_W].
- ch_valid  output  NUM_CH  one-cycle pulse per channel when its register updates.
- frame_done  output  1  one-cycle pulse when the last channel of a frame completes.
- locked  output  1  1 while in RECV state.
- sync_err  output  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ch_data=0, ch_valid=0, frame_done=0, locked=0, sync_err=0.
  - bit_cnt=0, ch_cnt=0, shift register cleared, state=HUNT.
  - Reset mid-frame discards the partial slot; no pulses are generated for it.
- Cycles with bit_en=0: no state, counter or shift change. Pulse outputs are 0.
- Frame position: p = ch_cnt*CH_W + bit_cnt, where 0 is channel 0 MSB.
- State HUNT:
  - locked=0.
  - bit_en=1 with fsync=1: shift in din, bit_cnt=1, ch_cnt=0, go RECV.
  - bit_en=1 with fsync=0: bit discarded, stay HUNT, no sync_err.
- State RECV (locked=1), on each bit_en=1:
  - Normal bit (fsync=0, p!=0): shift din in (MSB first) and increment bit_cnt.
  - Slot complete (bit_cnt==CH_W-1 on this bit):
    - Next cycle: ch_data slot ch_cnt = completed shift value, and ch_valid[ch_cnt]=1 for exactly one cycle.
    - bit_cnt returns to 0.
    - ch_cnt increments, or wraps to 0 after NUM_CH-1.
    - On the NUM_CH-1 slot, frame_done=1 in the same cycle as ch_valid[NUM_CH-1].
  - fsync=1 at p==0: expected; treat as a normal channel 0 MSB.
  - fsync=0 at p==0 (missing sync):
    - Next cycle: sync_err=1.
    - Bit discarded, go HUNT.
    - Previously completed channel data retained.
  - fsync=1 at p!=0 (early or misplaced sync):
    - Next cycle: sync_err=1.
    - Partial slot discarded, with no ch_valid for it.
    - This bit becomes channel 0 MSB: bit_cnt=1, ch_cnt=0, stay RECV.
- Output latency: 1 clock after the bit_en cycle carrying the slot LSB.
- ch_data holds its value until that slot is overwritten by a new completed slot.
- At most one ch_valid bit is high in any cycle. frame_done never asserts without ch_valid[NUM_CH-1].
- Counters are sized for CH_W and NUM_CH; wrap-around is exact, with no out-of-range values.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-stream -> all outputs 0 immediately, locked=0; after release, bits with fsync=0 keep HUNT with no sync_err.
- Lock and single frame (defaults): send fsync on the first bit, then slots 0xA5, 0x3C, 0xFF, 0x01 MSB-first with bit_en every cycle ->
  - ch_valid[0..3] pulse once each, 8 cycles apart, each 1 cycle after the slot LSB.
  - ch_data = 0x01FF3CA5; frame_done coincides with ch_valid[3].
  - locked=1 throughout; sync_err never asserts.
- Gapped strobe: same frame with bit_en high every third cycle -> identical ch_data, and pulses still 1 cycle after each LSB strobe.
- Back-to-back frames: frame 0x11,0x22,0x33,0x44 followed immediately by 0x55,0x66,0x77,0x88 with fsync at each start ->
  - two frame_done pulses.
  - final ch_data = 0x88776655; no sync_err.
- Missing sync: second frame starts with fsync=0 -> sync_err pulse, locked drops to 0, ch_data keeps 0x44332211, and the next fsync relocks.
- Early sync: fsync at bit 3 of channel 2 -> sync_err pulse, no ch_valid[2], and a new frame starting at that bit decodes correctly.
